uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. It adds configurable frame format (data width, parity, stop bits) and an input FIFO, so the host can queue several words and they go out back-to-back with no idle gap. It sits between the SoC bus-side producer and the serial TX pin, and runs in the single system clock domain.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; must be ≥2.
DATA_BITS, 8, data bits per frame; legal range 5–9.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; 1 or 2.
FIFO_DEPTH, 4, number of FIFO entries; power of 2, ≥2.

Ports:
i_Clock  in  1  system clock; all state updates on the rising edge.
i_Reset  in  1  reset; asynchronous, active-high.
i_Tx_DV  in  1  write strobe; pushes i_Tx_Byte into the FIFO.
i_Tx_Byte  in  DATA_BITS  data word to queue.
o_Tx_Ready  out  1  FIFO not full; combinational from the occupancy count.
o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
o_Tx_Active  out  1  high while any frame bit is being driven.
o_Tx_Serial  out  1  serial line; idles high.
o_Tx_Done  out  1  one-cycle pulse at the end of each frame's final stop bit.

Behaviour:
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE.
- Reset asserted mid-frame aborts the frame. The line returns high asynchronously and the FIFO is emptied.
- Frame format: start bit (0), then data LSB first, then optional parity, then STOP_BITS stop bits (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Frame length is (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Parity: even parity = XOR of the data bits; odd parity = inverse of that XOR.
- FIFO push: on any edge where i_Tx_DV=1 and count<FIFO_DEPTH. A push while full is silently dropped, even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: count is unchanged.
- Pop/load timing: FSM in IDLE with count>0 pops on the next edge and enters START. A word pushed on edge E into an empty FIFO therefore drives o_Tx_Serial=0 from edge E+1.
- FSM states and transitions:
  - IDLE → START on non-empty FIFO.
  - START → DATA.
  - DATA → PARITY, or → STOP when PARITY_MODE=0.
  - PARITY → STOP.
  - STOP: → START when the FIFO is non-empty at the final-stop-bit boundary (pop on that same edge); otherwise → IDLE.
- Counters: a clock counter wraps at CLKS_PER_BIT-1; a bit index counts 0..DATA_BITS-1; a stop counter counts 0..STOP_BITS-1.
- o_Tx_Done: pulses on the edge that ends the last stop bit. It fires once per frame, including back-to-back frames.
- o_Tx_Active: high from START entry until return to IDLE, and stays high continuously across back-to-back frames.
- The shift register is loaded at pop, so FIFO contents may change freely during a frame.

Optional Feature:
UART_TX_CTS_EN: adds input i_Cts_n (active-low clear-to-send, assumed already synchronised).
- With the macro: the IDLE→START transition and the STOP→START chaining additionally require i_Cts_n=0. A frame already in progress always completes. While i_Cts_n=1 the FSM holds in IDLE with the line high and the FIFO keeps filling.
- Without the macro: the port is absent and the block always transmits when data is queued.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - a frame-length helper function.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop/count. The top level keeps the FSM, counters and shift register.

Test Plan:
- CLKS_PER_BIT=10, 8N1, push 0xA5 → serial 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; o_Tx_Done pulses 100 cycles after the start-bit falling edge; o_Tx_Active is high for exactly those 100 cycles.
- PARITY_MODE=1, push 0xA5 (four ones) → parity bit 0 and 110-cycle frame; repeat with PARITY_MODE=2 → parity bit 1.
- Push 0x11, 0x22, 0x33 on consecutive cycles → three frames with no idle gap, o_Tx_Active never drops, three o_Tx_Done pulses spaced 100 cycles apart.
- FIFO_DEPTH=4, push 6 words on consecutive cycles from idle → first word popped immediately, words 2–5 fill the FIFO (count=4, o_Tx_Ready=0), word 6 dropped; exactly 5 frames transmitted.
- DATA_BITS=7, STOP_BITS=2, push 7'h41 → frame 0,1,0,0,0,0,0,1,1,1 (100 cycles); o_Tx_Done follows the second stop bit.
- Assert i_Reset at cycle 35 of a frame with 2 words queued → o_Tx_Serial=1 immediately, count=0, no o_Tx_Done; after release the line stays idle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // Total clock cycles occupied by one frame on the serial line.
  function automatic int unsigned frame_cycles(
    input int unsigned clks_per_bit,
    input int unsigned data_bits,
    input int unsigned parity_mode,
    input int unsigned stop_bits
  );
    return (1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is dropped even if a pop
// happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format fed from an input FIFO.
// Define UART_TX_CTS_EN to add the active-low i_Cts_n flow-control input.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
`ifdef UART_TX_CTS_EN
  input  logic                          i_Cts_n,
`endif
  output logic                          o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 cts_ok;
  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;

`ifdef UART_TX_CTS_EN
  assign cts_ok = ~i_Cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  assign bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign last_stop = (state == STOP) && bit_end && (stop_cnt == 1'(STOP_BITS - 1));
  assign pop       = ~fifo_empty & cts_ok & ((state == IDLE) | last_stop);
  assign o_Tx_Ready = ~fifo_full;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst   (i_Reset),
    .push  (i_Tx_DV),
    .wdata (i_Tx_Byte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (o_Fifo_Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
      shift       <= '0;
      par_bit     <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      clk_cnt   <= (bit_end || state == IDLE) ? '0 : clk_cnt + 1'b1;

      case (state)
        IDLE: ;
        START: begin
          if (bit_end) begin
            o_Tx_Serial <= shift[0];
            bit_idx     <= '0;
            state       <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
              if (PARITY_MODE != PAR_NONE) begin
                o_Tx_Serial <= par_bit;
                state       <= PARITY;
              end else begin
                o_Tx_Serial <= 1'b1;
                state       <= STOP;
              end
            end else begin
              bit_idx     <= bit_idx + 1'b1;
              shift       <= shift >> 1;
              o_Tx_Serial <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            o_Tx_Serial <= 1'b1;
            stop_cnt    <= 1'b0;
            state       <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              o_Tx_Done   <= 1'b1;
              o_Tx_Serial <= 1'b1;
              o_Tx_Active <= 1'b0;
              state       <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A pop from IDLE or at the last stop boundary overrides the case above,
      // so back-to-back frames chain without passing through IDLE.
      if (pop) begin
        shift       <= fifo_rdata;
        par_bit     <= (PARITY_MODE == PAR_ODD) ? ~(^fifo_rdata) : (^fifo_rdata);
        o_Tx_Serial <= 1'b0;
        o_Tx_Active <= 1'b1;
        state       <= START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: 8N1, 8E1, 8O1 and 7N2 instances sharing clock and reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dv  = '0;
  logic [8:0] din = '0;
  logic [3:0] ser, act, done, rdy;
  logic [3:0][2:0] cnt;
  int cur = 0;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[7:0]),
    .o_Tx_Ready(rdy[0]), .o_Fifo_Count(cnt[0]), .o_Tx_Active(act[0]),
    .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[7:0]),
    .o_Tx_Ready(rdy[1]), .o_Fifo_Count(cnt[1]), .o_Tx_Active(act[1]),
    .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(10), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[7:0]),
    .o_Tx_Ready(rdy[2]), .o_Fifo_Count(cnt[2]), .o_Tx_Active(act[2]),
    .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(10), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[6:0]),
    .o_Tx_Ready(rdy[3]), .o_Fifo_Count(cnt[3]), .o_Tx_Active(act[3]),
    .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));

  typedef struct {
    int         unit;
    logic [8:0] data;
    string      bits;   // expected line level per bit period, in wire order
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    n   = v.bits.len() * 10;
    cur = v.unit;
    @(negedge clk);
    din = v.data;
    dv[v.unit] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv = '0;
    check("pre_serial", ser[cur], 1);
    check("pre_count", cnt[cur], 1);
    check("pre_ready", rdy[cur], 1);
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("frame_serial", ser[cur], (v.bits[k/10] == "1") ? 1 : 0);
      check("frame_active", act[cur], 1);
      check("frame_done", done[cur], 0);
    end
    @(negedge clk);
    check("end_done", done[cur], 1);
    check("end_active", act[cur], 0);
    check("end_serial", ser[cur], 1);
    @(negedge clk);
    check("post_done", done[cur], 0);
  endtask

  // 8N1 stream on u0; stops early (without checking that cycle) at abort_k.
  task automatic run_stream(input logic [7:0] w[6], input int npush,
                            input int nframes, input int abort_k);
    int f, b, exp_ser;
    cur = 0;
    @(negedge clk);
    din = {1'b0, w[0]};
    dv[0] = 1'b1;
    fork
      begin
        for (int i = 1; i < npush; i++) begin
          @(negedge clk);
          din = {1'b0, w[i]};
        end
        @(negedge clk);
        dv = '0;
      end
      begin
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < nframes * 100 + 3; k++) begin
          @(negedge clk);
          if (k == abort_k) break;
          f = k / 100;
          b = (k % 100) / 10;
          if (f >= nframes) exp_ser = 1;
          else if (b == 0)  exp_ser = 0;
          else if (b == 9)  exp_ser = 1;
          else              exp_ser = w[f][b-1];
          check("stream_serial", ser[0], exp_ser);
          check("stream_active", act[0], (k < nframes * 100) ? 1 : 0);
          check("stream_done", done[0], (k > 0 && k % 100 == 0 && k <= nframes * 100) ? 1 : 0);
          if (npush == 6 && k == 4) begin
            check("full_count", cnt[0], 4);
            check("full_ready", rdy[0], 0);
          end
        end
      end
    join
  endtask

  initial begin
    logic [7:0] w[6];

    vecs[0] = '{0, 9'h0A5, "0101001011"};
    vecs[1] = '{0, 9'h000, "0000000001"};
    vecs[2] = '{0, 9'h0FF, "0111111111"};
    vecs[3] = '{0, 9'h03C, "0001111001"};
    vecs[4] = '{1, 9'h0A5, "01010010101"};
    vecs[5] = '{1, 9'h001, "01000000011"};
    vecs[6] = '{2, 9'h0A5, "01010010111"};
    vecs[7] = '{2, 9'h000, "00000000011"};

    repeat (3) @(negedge clk);
    check("rst_serial", ser[0], 1);
    check("rst_active", act[0], 0);
    check("rst_done", done[0], 0);
    check("rst_count", cnt[0], 0);
    check("rst_ready", rdy[0], 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_serial", ser[0], 1);
    check("idle_active", act[0], 0);

    foreach (vecs[i]) run_frame(vecs[i]);
    run_frame('{3, 9'h041, "0100000111"});

    w = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    run_stream(w, 3, 3, -1);

    w = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hC3, 8'h7E};
    run_stream(w, 6, 5, -1);
    check("drain_count", cnt[0], 0);

    w = '{8'h5A, 8'h3C, 8'hF0, 8'h00, 8'h00, 8'h00};
    run_stream(w, 3, 3, 35);
    check("abort_pre_count", cnt[0], 2);
    #1 rst = 1'b1;
    #1;
    check("abort_serial", ser[0], 1);
    check("abort_active", act[0], 0);
    check("abort_count", cnt[0], 0);
    check("abort_ready", rdy[0], 1);
    check("abort_done", done[0], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      check("after_serial", ser[0], 1);
      check("after_done", done[0], 0);
      check("after_active", act[0], 0);
    end
    check("after_count", cnt[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
